// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative radix-2 restoring divider for the EX stage.
// Produces {remainder, quotient} for div/divu after WIDTH+1 edges, stalling
// the pipeline meanwhile. Optional macro DIV_ZERO_SHORTCUT_EN lets a zero
// dividend with a nonzero divisor finish in one edge.
//
// state      | meaning
// S_IDLE     | waiting for a start request
// S_DIVZERO  | divisor was zero, result forced to 0 next edge
// S_ON       | one restoring iteration per cycle
// S_END      | result valid, held until start_i drops
module ex_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 stallreq_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DIVZERO = 2'd1;
  localparam logic [1:0] S_ON      = 2'd2;
  localparam logic [1:0] S_END     = 2'd3;
  localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [2*WIDTH:0]   work_q, work_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               neg1_q, neg1_d;
  logic               neg2_q, neg2_d;
  logic               signed_q, signed_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH-1:0]   mag1, mag2;
  logic               trial_ok;
  logic [WIDTH-1:0]   trial;
  logic [2*WIDTH:0]   work_shift;
  logic [WIDTH-1:0]   quot, rem, quot_fix, rem_fix;

  // Operand magnitudes; the most negative value maps to its unsigned magnitude.
  assign mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // Upper part is compared at WIDTH+1 bits so a divisor above 2^(WIDTH-1)
  // cannot lose the carried-out partial-remainder bit. When the trial
  // succeeds the difference is below the divisor, so WIDTH bits suffice.
  assign trial_ok   = work_q[2*WIDTH:WIDTH] >= {1'b0, divisor_q};
  assign trial      = work_q[2*WIDTH-1:WIDTH] - divisor_q;
  assign work_shift = trial_ok ? {trial, work_q[WIDTH-1:0], 1'b1}
                               : {work_q[2*WIDTH-1:0], 1'b0};

  assign quot     = work_shift[WIDTH-1:0];
  assign rem      = work_shift[2*WIDTH:WIDTH+1];
  assign quot_fix = (signed_q && (neg1_q ^ neg2_q)) ? -quot : quot;
  assign rem_fix  = (signed_q && neg1_q) ? -rem : rem;

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    neg1_d    = neg1_q;
    neg2_d    = neg2_q;
    signed_d  = signed_q;
    result_d  = result_q;
    ready_d   = ready_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = S_DIVZERO;
          end
`ifdef DIV_ZERO_SHORTCUT_EN
          else if (opdata1_i == '0) begin
            state_d  = S_END;
            ready_d  = 1'b1;
            result_d = '0;
          end
`endif
          else begin
            state_d   = S_ON;
            cnt_d     = '0;
            divisor_d = mag2;
            work_d    = {{WIDTH{1'b0}}, mag1, 1'b0};
            neg1_d    = signed_div_i & opdata1_i[WIDTH-1];
            neg2_d    = signed_div_i & opdata2_i[WIDTH-1];
            signed_d  = signed_div_i;
          end
        end
      end
      S_DIVZERO: begin
        state_d  = S_END;
        ready_d  = 1'b1;
        result_d = '0;
      end
      S_ON: begin
        if (annul_i || !start_i) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          result_d = '0;
        end else begin
          work_d = work_shift;
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q == LAST_ITER) begin
            state_d  = S_END;
            ready_d  = 1'b1;
            result_d = {rem_fix, quot_fix};
          end
        end
      end
      S_END: begin
        if (!start_i || annul_i) begin
          state_d  = S_IDLE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers, cleared asynchronously even mid-division.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      signed_q  <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      neg1_q    <= neg1_d;
      neg2_q    <= neg2_d;
      signed_q  <= signed_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = rst & start_i & ~ready_q;

endmodule
